// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: word width, reserved
// encodings, FSM state type and the queue entry layout.
package instruction_fetch_pkg;

  localparam int unsigned INTERNAL_BITS = 32;
  localparam int unsigned OPCODE        = 6;

  // HLT is the all-ones primary opcode with a zero body; NOP is the all-zero word.
  localparam logic [INTERNAL_BITS-1:0] HLT     = 32'hFC00_0000;
  localparam logic [INTERNAL_BITS-1:0] NOP     = '0;
  localparam logic [INTERNAL_BITS-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StWait  = 3'd2,
    StDrain = 3'd3,
    StHalt  = 3'd4
  } if_state_e;

  typedef struct packed {
    logic [INTERNAL_BITS-1:0] word;
    logic [INTERNAL_BITS-1:0] pc;
  } if_entry_t;

  function automatic logic is_halt(input logic [INTERNAL_BITS-1:0] word);
    return word == HLT;
  endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Power-of-two FIFO of {word, pc} entries between fetch and decode.
// Clear has priority over push and pop; the caller never pushes when full.
module fetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  if_entry_t       entry_i,
  output if_entry_t       head_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  if_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem requests,
// flush/redirect with drain of an in-flight request, and stop after HLT.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned              QDEPTH   = 2,
  parameter logic [INTERNAL_BITS-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [INTERNAL_BITS-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic [INTERNAL_BITS-1:0] imem_rdata,
  input  logic                     stall,
  input  logic                     IF_flush,
  input  logic [INTERNAL_BITS-1:0] redirect_pc,
  output logic [INTERNAL_BITS-1:0] instr,
  output logic [INTERNAL_BITS-1:0] instr_pc,
  output logic                     instr_valid,
  output logic                     halt_seen
);

  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  if_state_e                state_q;
  logic [INTERNAL_BITS-1:0] pc_q;
  logic [INTERNAL_BITS-1:0] drain_addr_q;
  logic                     halt_q;

  logic [CntW-1:0] count;
  logic            q_empty;
  if_entry_t       head;
  if_entry_t       push_entry;
  logic            push;
  logic            pop;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      StFetch: imem_req = (count < CntW'(QDEPTH));
      StWait:  imem_req = 1'b1;
      StDrain: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
      default: ;
    endcase
  end

  // A flush squashes both the arriving response and any pop in the same cycle.
  always_comb begin
    push = imem_req && imem_ready && !IF_flush &&
           ((state_q == StFetch) || (state_q == StWait));
    pop  = !q_empty && !stall && !IF_flush;
    push_entry.word = imem_rdata;
    push_entry.pc   = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      halt_q       <= 1'b0;
    end else if (IF_flush) begin
      pc_q   <= redirect_pc;
      halt_q <= 1'b0;
      // An unanswered request must still complete before fetching resumes.
      if (imem_req && !imem_ready) begin
        state_q      <= StDrain;
        drain_addr_q <= imem_addr;
      end else begin
        state_q <= StFetch;
      end
    end else begin
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch, StWait: begin
          if (push) begin
            pc_q <= pc_q + PC_STEP;
            if (is_halt(imem_rdata)) begin
              state_q <= StHalt;
              halt_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end else if (imem_req) begin
            state_q <= StWait;
          end
        end
        StDrain: if (imem_ready) state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  fetch_queue #(
    .Depth (QDEPTH),
    .CntW  (CntW)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (IF_flush),
    .entry_i (push_entry),
    .head_o  (head),
    .count_o (count),
    .empty_o (q_empty)
  );

  assign instr_valid = !q_empty;
  assign instr       = q_empty ? NOP : head.word;
  assign instr_pc    = q_empty ? '0 : head.pc;
  assign halt_seen   = halt_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the pipelined core, directly upstream of `Controller`. It sequences the PC, issues single-outstanding requests to instruction memory, and buffers returned words in a small queue that feeds the IF/ID boundary. `Controller` and the decode stage consume its `instr` output. It squashes and redirects on `IF_flush` and stops fetching after it has delivered `HLT`.

## Interface
- `QDEPTH`, 2: instruction queue entries; must be a power of two and at least 2.
- `RESET_PC`, 0: first fetch address after reset.
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  `INTERNAL_BITS`  fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready`  in  1  response strobe; may assert in the same cycle as the request.
- `imem_rdata`  in  `INTERNAL_BITS`  fetched word; valid when `imem_ready`=1.
- `stall`  in  1  decode hold from the hazard logic; blocks the pop.
- `IF_flush`  in  1  squash plus redirect.
- `redirect_pc`  in  `INTERNAL_BITS`  new PC; sampled when `IF_flush`=1.
- `instr`  out  `INTERNAL_BITS`  queue head, or `NOP` (all zeros) when the queue is empty.
- `instr_pc`  out  `INTERNAL_BITS`  PC of the head entry; 0 when the queue is empty.
- `instr_valid`  out  1  queue is non-empty.
- `halt_seen`  out  1  high while the block is in HALT.

## Operation
- **States:** IDLE, FETCH, WAIT, DRAIN, HALT. Reset enters IDLE.
- **IDLE:** `imem_req`=0 for exactly one cycle, then FETCH.
- **FETCH:**
  - `imem_req` = (count < QDEPTH), with `imem_addr`=pc.
  - Request with `imem_ready`=1: push {`imem_rdata`, pc}, pc += 4, stay in FETCH.
  - Request with `imem_ready`=0: go to WAIT.
- **WAIT:** `imem_req`=1 and the address is held. On `imem_ready`: push, pc += 4, go to FETCH.
- **HLT handling:** a pushed word equal to `HLT` is still delivered to decode. The next state is HALT in place of FETCH.
- **HALT:** `imem_req`=0 and `halt_seen`=1. The queue keeps draining normally.
- **Pop:** on `instr_valid` && !`stall`. Push and pop in the same cycle leave count unchanged.
- **Queue pointers:** wrap modulo QDEPTH. A push is impossible when full, because no request is issued at count == QDEPTH.
- **`IF_flush`:** priority is above push, pop and stall.
  - The queue is cleared next cycle.
  - pc <= `redirect_pc`.
  - FETCH with request and no ready, or WAIT with no ready: go to DRAIN.
  - A response arriving in the flush cycle itself is discarded, and the next state is FETCH.
  - IDLE, HALT, or FETCH without a request: go to FETCH.
  - In DRAIN: stay in DRAIN; pc takes the latest `redirect_pc`.
- **DRAIN:** `imem_req`=1 on the old address until `imem_ready`. The data is discarded, then go to FETCH at pc.
- **Arithmetic:** pc += 4 wraps modulo 2^`INTERNAL_BITS`.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=0, `instr_pc`=0, `instr_valid`=0, `halt_seen`=0, queue empty, pc=`RESET_PC`.
- **Reset mid-operation:** immediate return to the reset values. An outstanding memory response after reset release is ignored, since IDLE does not accept responses.
- **Latency:** `imem_ready` in cycle t makes the word visible on `instr` in cycle t+1.
- **First request:** the 2nd cycle after `rst` deassertion.
- **Throughput:** 1 instruction/cycle with zero-wait memory and no stall.
- **Outputs:** all are flop-driven or decoded from flops and the queue; none is combinational from any input except `imem_req`, `imem_addr` and the push path.

## Structure
- **Shared `def.v`:** `INTERNAL_BITS`, `OPCODE`, `HLT`, `NOP`.
- **Local parameters:** state encodings (IDLE=3'd0, FETCH=3'd1, WAIT=3'd2, DRAIN=3'd3, HALT=3'd4).
- **Sub-module `fetch_queue`:** parameterised FIFO of {word, pc} with push, pop, clear, count, head outputs.

## Test plan
- **Reset:** `rst` pulsed mid-WAIT -> all outputs take their reset values immediately; one IDLE cycle; then `imem_req`=1 with `imem_addr`=0.
- **Zero-wait stream:** `imem_ready` tied 1, words 0x00221820, 0x8C030004, 0xAC030008 -> `instr_valid` high from the 3rd cycle; `instr_pc` 0, 4, 8 on consecutive cycles.
- **Stall to full:** `stall`=1 with zero-wait memory -> exactly 2 entries (PC 0, 4); `imem_req` drops; head holds. Release `stall` -> PC 0, 4, 8 in order with no gap.
- **Flush in WAIT:** request for 0x8 pending, `IF_flush`=1 with `redirect_pc`=0x40 -> next cycle `instr_valid`=0 and state DRAIN. `imem_addr` stays 0x8 until `imem_ready`; that word never appears; next request is at 0x40.
- **HLT:** `HLT` returned for 0x10 -> it appears on `instr` with `instr_pc`=0x10; `halt_seen`=1; `imem_req`=0 indefinitely. Then `IF_flush` with `redirect_pc`=0x20 -> `halt_seen`=0 and a request at 0x20.
- **Simultaneous events:** `IF_flush`, `stall` and `imem_ready` all in one cycle with 1 queued entry -> the response is discarded; the queue is empty next cycle; fetch resumes at `redirect_pc`.
